// File: rtl/sd_req_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sd_req_arbiter_if : SD sector channel of the SPI user I/O block              |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
interface sd_req_arbiter_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_dout;
    logic        sd_dout_strobe;
    logic [7:0]  sd_din;
    logic        sd_din_strobe;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_din,
        input  sd_ack, sd_dout, sd_dout_strobe, sd_din_strobe
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_din,
        output sd_ack, sd_dout, sd_dout_strobe, sd_din_strobe
    );
endinterface
`default_nettype wire

// File: rtl/sd_req_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sd_req_arbiter : round-robin sharing of the SD sector channel between NREQ   |
// | requesters, with SPI-domain handshake sync and an acknowledge watchdog.      |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module sd_req_arbiter #(
    parameter int          NREQ    = 2,
    parameter logic [23:0] TIMEOUT = 24'd12000000
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_rd,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [32*NREQ-1:0] req_lba,
    output logic [NREQ-1:0]    req_done,
    output logic [NREQ-1:0]    req_err,
    output logic [NREQ-1:0]    gnt,
    output logic [8:0]         buf_addr,
    output logic [7:0]         buf_dout,
    output logic               buf_we,
    input  logic [8*NREQ-1:0]  buf_din,
    sd_req_arbiter_if.master   sd
);

    localparam int              c_IW  = (NREQ > 2) ? 2 : 1;
    localparam logic [NREQ-1:0] c_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_IW-1:0] r_idx;
    logic [c_IW-1:0] r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_req_done;
    logic [NREQ-1:0] r_req_err;
    logic [31:0]     r_sd_lba;
    logic            r_sd_rd;
    logic            r_sd_wr;
    logic            r_is_wr;
    logic [7:0]      r_sd_din;
    logic [7:0]      r_buf_dout;
    logic            r_buf_we;
    logic [8:0]      r_buf_addr;
    logic [10:0]     r_count;
    logic [23:0]     r_wdog;

    logic [2:0]      r_ack_s;
    logic [2:0]      r_dstb_s;
    logic [2:0]      r_istb_s;
    logic [7:0]      r_dout_s1;
    logic [7:0]      r_dout_s2;

    logic            w_ack_r;
    logic            w_ack_f;
    logic            w_dstb;
    logic            w_istb;
    logic [NREQ-1:0] w_pending;
    logic            w_any;
    logic [c_IW-1:0] w_sel;
    logic            w_cnt_inc;
    logic [10:0]     w_count_nx;
    logic            w_xfer_ok;
    logic [7:0]      w_buf_din;

    // Two flops for metastability, a third only to detect edges.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_s   <= '0;
            r_dstb_s  <= '0;
            r_istb_s  <= '0;
            r_dout_s1 <= '0;
            r_dout_s2 <= '0;
        end else begin
            r_ack_s   <= {r_ack_s[1:0],  sd.sd_ack};
            r_dstb_s  <= {r_dstb_s[1:0], sd.sd_dout_strobe};
            r_istb_s  <= {r_istb_s[1:0], sd.sd_din_strobe};
            r_dout_s1 <= sd.sd_dout;
            r_dout_s2 <= r_dout_s1;
        end
    end

    assign w_ack_r   =  r_ack_s[1]  & ~r_ack_s[2];
    assign w_ack_f   = ~r_ack_s[1]  &  r_ack_s[2];
    assign w_dstb    =  r_dstb_s[1] & ~r_dstb_s[2];
    assign w_istb    =  r_istb_s[1] & ~r_istb_s[2];
    assign w_pending = req_rd | req_wr;
    assign w_buf_din = buf_din[8*r_idx +: 8];

    // Lowest offset from the pointer wins, so iterate downward and let it overwrite.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_pending[(int'(r_ptr) + k) % NREQ]) begin
                w_any = 1'b1;
                w_sel = c_IW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    // Reads stop counting at 512 so extra bytes are dropped; writes saturate.
    always_comb begin
        w_cnt_inc = 1'b0;
        if (r_state == S_XFER) begin
            if (r_is_wr) w_cnt_inc = w_istb && (r_count != 11'h7FF);
            else         w_cnt_inc = w_dstb && (r_count < 11'd512);
        end
    end

    assign w_count_nx = r_count + {10'd0, w_cnt_inc};
    assign w_xfer_ok  = r_is_wr ? (w_count_nx >= 11'd512) : (w_count_nx == 11'd512);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_req_done <= '0;
            r_req_err  <= '0;
            r_sd_lba   <= '0;
            r_sd_rd    <= 1'b0;
            r_sd_wr    <= 1'b0;
            r_is_wr    <= 1'b0;
            r_sd_din   <= '0;
            r_buf_dout <= '0;
            r_buf_we   <= 1'b0;
            r_buf_addr <= '0;
            r_count    <= '0;
            r_wdog     <= '0;
        end else begin
            r_buf_we   <= 1'b0;
            r_req_done <= '0;
            r_req_err  <= '0;
            if (r_buf_we) r_buf_addr <= r_buf_addr + 9'd1;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_idx      <= w_sel;
                        r_gnt      <= c_ONE << w_sel;
                        r_sd_lba   <= req_lba[32*w_sel +: 32];
                        r_sd_rd    <= req_rd[w_sel];
                        r_sd_wr    <= ~req_rd[w_sel];
                        r_is_wr    <= ~req_rd[w_sel];
                        r_buf_addr <= '0;
                        r_count    <= '0;
                        r_wdog     <= '0;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_wdog <= r_wdog + 24'd1;
                    if (w_ack_r) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_state <= S_XFER;
                    end else if (r_wdog == TIMEOUT - 24'd1) begin
                        r_sd_rd   <= 1'b0;
                        r_sd_wr   <= 1'b0;
                        r_req_err <= r_gnt;
                        r_state   <= S_DONE;
                    end
                end
                S_XFER: begin
                    if (!r_is_wr && w_cnt_inc) begin
                        r_buf_dout <= r_dout_s2;
                        r_buf_we   <= 1'b1;
                    end
                    if (r_is_wr && w_istb) begin
                        r_sd_din   <= w_buf_din;
                        r_buf_addr <= r_buf_addr + 9'd1;
                    end
                    r_count <= w_count_nx;
                    if (w_ack_f) begin
                        if (w_xfer_ok) r_req_done <= r_gnt;
                        else           r_req_err  <= r_gnt;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_gnt   <= '0;
                    r_ptr   <= (r_idx == c_IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign req_done  = r_req_done;
    assign req_err   = r_req_err;
    assign buf_addr  = r_buf_addr;
    assign buf_dout  = r_buf_dout;
    assign buf_we    = r_buf_we;
    assign sd.sd_lba = r_sd_lba;
    assign sd.sd_rd  = r_sd_rd;
    assign sd.sd_wr  = r_sd_wr;
    assign sd.sd_din = r_sd_din;

endmodule
`default_nettype wire

// File: tb/tb_sd_req_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | tb_sd_req_arbiter : directed vectors and corner sequences for sd_req_arbiter |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module tb_sd_req_arbiter;

    localparam int NREQ = 2;

    logic               clk_sys = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req_rd;
    logic [NREQ-1:0]    req_wr;
    logic [32*NREQ-1:0] req_lba;
    logic [NREQ-1:0]    req_done;
    logic [NREQ-1:0]    req_err;
    logic [NREQ-1:0]    gnt;
    logic [8:0]         buf_addr;
    logic [7:0]         buf_dout;
    logic               buf_we;
    logic [8*NREQ-1:0]  buf_din;

    sd_req_arbiter_if sd ();

    sd_req_arbiter #(.NREQ(NREQ), .TIMEOUT(24'd100)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .req_rd   (req_rd),
        .req_wr   (req_wr),
        .req_lba  (req_lba),
        .req_done (req_done),
        .req_err  (req_err),
        .gnt      (gnt),
        .buf_addr (buf_addr),
        .buf_dout (buf_dout),
        .buf_we   (buf_we),
        .buf_din  (buf_din),
        .sd       (sd)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          r;
        bit          rd;
        bit          wr;
        logic [31:0] lba;
        int          nbytes;
        logic [7:0]  pat;
        bit          exp_ok;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [NREQ][512];

    // Sync-RAM read model for the requester buffers.
    always @(posedge clk_sys) buf_din <= {ram[1][buf_addr], ram[0][buf_addr]};

    int         mon_we = 0;
    logic [8:0] cap_addr [8192];
    logic [7:0] cap_data [8192];
    int         mon_done [NREQ] = '{default: 0};
    int         mon_err  [NREQ] = '{default: 0};

    always @(negedge clk_sys) begin
        if (buf_we && mon_we < 8192) begin
            cap_addr[mon_we] = buf_addr;
            cap_data[mon_we] = buf_dout;
            mon_we++;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_done[i]) mon_done[i]++;
            if (req_err[i])  mon_err[i]++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_sys);
            if (sd.sd_rd || sd.sd_wr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_sys);
            if ((req_done | req_err) != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic strobe_rd(input logic [7:0] b);
        sd.sd_dout        = b;
        sd.sd_dout_strobe = 1'b1;
        tick(3);
        sd.sd_dout_strobe = 1'b0;
        tick(3);
    endtask

    task automatic strobe_wr();
        sd.sd_din_strobe = 1'b1;
        tick(3);
        sd.sd_din_strobe = 1'b0;
        tick(3);
    endtask

    task automatic run_vec(input vec_t v);
        bit              ok;
        int              base_we;
        int              d0;
        int              e0;
        int              mism;
        int              nexp;
        logic [7:0]      first;
        logic [NREQ-1:0] dv;
        logic [NREQ-1:0] ev;
        base_we = mon_we;
        d0      = mon_done[v.r];
        e0      = mon_err[v.r];
        mism    = 0;
        first   = 8'h00;
        req_lba[32*v.r +: 32] = v.lba;
        req_rd[v.r] = v.rd;
        req_wr[v.r] = v.wr;
        wait_grant(ok);
        chk("grant_seen", 32'(ok), 1);
        if (!ok) begin
            req_rd = '0;
            req_wr = '0;
            return;
        end
        chk("gnt", 32'(gnt), 32'(1 << v.r));
        chk("sd_lba", sd.sd_lba, v.lba);
        chk("sd_rd", 32'(sd.sd_rd), 32'(v.rd));
        chk("sd_wr", 32'(sd.sd_wr), 32'(!v.rd));
        sd.sd_ack = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_sys);
            if (!sd.sd_rd && !sd.sd_wr) begin
                ok = 1'b1;
                break;
            end
        end
        chk("cmd_drop_on_ack", 32'(ok), 1);
        for (int n = 0; n < v.nbytes; n++) begin
            if (v.rd) begin
                strobe_rd(8'(n) ^ v.pat);
            end else begin
                strobe_wr();
                if (n == 0) first = sd.sd_din;
                if (sd.sd_din !== ram[v.r][n % 512]) mism++;
            end
        end
        sd.sd_ack = 1'b0;
        wait_end(ok);
        dv = req_done;
        ev = req_err;
        req_rd[v.r] = 1'b0;
        req_wr[v.r] = 1'b0;
        chk("completion_seen", 32'(ok), 1);
        chk("req_done", 32'(dv), v.exp_ok ? 32'(1 << v.r) : 32'd0);
        chk("req_err", 32'(ev), v.exp_ok ? 32'd0 : 32'(1 << v.r));
        tick(3);
        chk("done_pulse_cycles", 32'(mon_done[v.r] - d0), 32'(v.exp_ok));
        chk("err_pulse_cycles", 32'(mon_err[v.r] - e0), 32'(!v.exp_ok));
        chk("gnt_idle", 32'(gnt), 0);
        if (v.rd) begin
            nexp = (v.nbytes > 512) ? 512 : v.nbytes;
            chk("buf_we_count", 32'(mon_we - base_we), 32'(nexp));
            for (int k = 0; k < nexp; k++) begin
                if (cap_addr[base_we + k] !== 9'(k))              mism++;
                if (cap_data[base_we + k] !== (8'(k) ^ v.pat))    mism++;
            end
            chk("rd_byte_mismatches", 32'(mism), 0);
        end else begin
            chk("wr_first_byte", 32'(first), 32'(ram[v.r][0]));
            chk("wr_byte_mismatches", 32'(mism), 0);
            chk("no_buf_we_on_write", 32'(mon_we - base_we), 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t vecs [6];
        bit   ok;
        int   cnt;
        logic [NREQ-1:0] exp_g;

        vecs[0] = '{0, 1'b1, 1'b0, 32'h0000_1234, 512, 8'h00, 1'b1};
        vecs[1] = '{1, 1'b0, 1'b1, 32'hDEAD_BEEF, 513, 8'h00, 1'b1};
        vecs[2] = '{0, 1'b1, 1'b0, 32'h0000_0042, 300, 8'h5A, 1'b0};
        vecs[3] = '{1, 1'b1, 1'b1, 32'h00AB_CDEF, 513, 8'hC3, 1'b1};
        vecs[4] = '{0, 1'b0, 1'b1, 32'h0000_0007, 511, 8'h00, 1'b0};
        vecs[5] = '{1, 1'b0, 1'b1, 32'h0000_FFFF, 512, 8'h00, 1'b1};

        for (int n = 0; n < 512; n++) begin
            ram[0][n] = 8'(n) ^ 8'h3C;
            ram[1][n] = 8'(n) ^ 8'hA5;
        end

        reset_n           = 1'b0;
        req_rd            = '0;
        req_wr            = '0;
        req_lba           = '0;
        sd.sd_ack         = 1'b0;
        sd.sd_dout        = '0;
        sd.sd_dout_strobe = 1'b0;
        sd.sd_din_strobe  = 1'b0;
        tick(3);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_sd_rd", 32'(sd.sd_rd), 0);
        chk("rst_sd_wr", 32'(sd.sd_wr), 0);
        chk("rst_buf_we", 32'(buf_we), 0);
        chk("rst_done_err", 32'({req_done, req_err}), 0);
        chk("rst_sd_lba", sd.sd_lba, 0);
        chk("rst_buf_addr", 32'(buf_addr), 0);
        chk("rst_sd_din", 32'(sd.sd_din), 0);
        chk("rst_buf_dout", 32'(buf_dout), 0);
        reset_n = 1'b1;
        tick(3);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Contention: both held, grants must alternate starting at requester 0.
        req_lba = {32'h0000_0B0B, 32'h0000_0A0A};
        req_rd  = 2'b11;
        for (int g = 0; g < 3; g++) begin
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            wait_grant(ok);
            chk("contention_grant_seen", 32'(ok), 1);
            chk("contention_gnt", 32'(gnt), 32'(exp_g));
            sd.sd_ack = 1'b1;
            tick(6);
            sd.sd_ack = 1'b0;
            wait_end(ok);
            chk("contention_err", 32'(req_err), 32'(exp_g));
            if (g == 2) req_rd = '0;
        end
        tick(4);

        // Watchdog: no ack for requester 0, then requester 1 must be next.
        req_rd = 2'b01;
        wait_grant(ok);
        chk("to_grant_seen", 32'(ok), 1);
        req_rd = 2'b11;
        cnt = 0;
        while (sd.sd_rd && cnt < 200) begin
            cnt++;
            @(negedge clk_sys);
        end
        chk("timeout_cycles", 32'(cnt), 100);
        chk("timeout_err", 32'(req_err), 32'b01);
        chk("timeout_no_done", 32'(req_done), 0);
        wait_grant(ok);
        chk("to_next_gnt", 32'(gnt), 32'b10);
        wait_end(ok);
        chk("to_second_err", 32'(req_err), 32'b10);
        req_rd = '0;
        tick(5);
        chk("to_idle_gnt", 32'(gnt), 0);

        // Reset in the middle of a read transfer, during a buf_we pulse.
        req_lba[31:0] = 32'h0000_0200;
        req_rd = 2'b01;
        wait_grant(ok);
        sd.sd_ack = 1'b1;
        tick(6);
        for (int n = 0; n < 199; n++) strobe_rd(8'(n));
        sd.sd_dout        = 8'hC7;
        sd.sd_dout_strobe = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_sys);
            if (buf_we) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_xfer_we_seen", 32'(ok), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_gnt", 32'(gnt), 0);
        chk("async_rst_buf_we", 32'(buf_we), 0);
        chk("async_rst_buf_addr", 32'(buf_addr), 0);
        chk("async_rst_sd_rd", 32'(sd.sd_rd), 0);
        sd.sd_dout_strobe = 1'b0;
        sd.sd_ack         = 1'b0;
        req_rd            = '0;
        tick(2);
        reset_n = 1'b1;
        tick(4);

        // Reset while a write command is still asserted.
        req_rd = '0;
        req_wr = 2'b10;
        wait_grant(ok);
        chk("rst_wr_cmd_up", 32'(sd.sd_wr), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_sd_wr", 32'(sd.sd_wr), 0);
        chk("async_rst_gnt_wr", 32'(gnt), 0);
        req_wr = '0;
        tick(2);
        reset_n = 1'b1;
        tick(4);

        run_vec('{0, 1'b1, 1'b0, 32'h0000_0300, 512, 8'h81, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_req_arbiter.md
Name: sd_req_arbiter

Overview:
Shares the single SD-card sector channel of the SPI user I/O block (sd_lba/sd_rd/sd_wr out; sd_ack/sd_dout/strobes in) between NREQ virtual-drive requesters in the core clock domain. Round-robin grant, one 512-byte sector per grant. Synchronises the SPI-domain handshake and moves bytes between the channel and the granted requester's sector buffer. A watchdog aborts requests the IO controller never acknowledges.

Parameters:
NREQ, 2, number of requesters (2..4)
TIMEOUT, 24'd12000000, clk_sys cycles in REQ without ack before abort

Ports:
clk_sys  in  1  core clock, must be >= 4x SPI_SCK
reset_n  in  1  asynchronous, active-low reset
req_rd  in  NREQ  per-requester sector read request, level, held until done/err
req_wr  in  NREQ  per-requester sector write request, level
req_lba  in  32*NREQ  per-requester LBA, requester i at [32i+31:32i]
req_done  out  NREQ  1-cycle pulse, sector finished OK
req_err  out  NREQ  1-cycle pulse, timeout or byte-count error
gnt  out  NREQ  one-hot current grant, 0 when idle
buf_addr  out  9  byte address into granted requester's buffer
buf_dout  out  8  byte to requester buffer (read)
buf_we  out  1  write strobe for buf_dout at buf_addr, 1 cycle
buf_din  in  8*NREQ  per-requester buffer read data, 1-cycle sync-RAM latency
sd_lba  out  32  to user I/O
sd_rd  out  1  to user I/O
sd_wr  out  1  to user I/O
sd_ack  in  1  SPI domain
sd_dout  in  8  SPI domain, stable while sd_dout_strobe high
sd_dout_strobe  in  1  SPI domain
sd_din  out  8  to user I/O
sd_din_strobe  in  1  SPI domain

Behaviour:
- Reset (async, immediate): state IDLE; gnt, sd_rd, sd_wr, buf_we, req_done, req_err = 0; sd_lba, buf_addr, sd_din, buf_dout = 0; round-robin pointer = 0.
- Sync: sd_ack, sd_dout_strobe, sd_din_strobe each pass 2 flops, then a 3rd flop for edge detect. ack_r/ack_f and dstb/istb are single-cycle rise/fall pulses.
- States: IDLE, REQ, XFER, DONE.
- IDLE: pending[i] = req_rd[i]|req_wr[i]. Pick first pending at or after the pointer, searching upward with wrap. Next cycle: gnt one-hot, sd_lba = req_lba[i], and sd_rd = req_rd[i] or, if req_rd[i] is low, sd_wr = 1. rd wins if both are set. buf_addr = 0, byte count = 0, watchdog = 0. Go to REQ.
- REQ: watchdog += 1. ack_r -> XFER. Watchdog == TIMEOUT-1 -> drop sd_rd/sd_wr, pulse req_err[i], go DONE.
- XFER, read: on dstb, buf_dout <= synced sd_dout and buf_we = 1 the next cycle at current buf_addr; then buf_addr += 1 and count += 1. buf_addr wraps 511 -> 0 and a 513th byte is ignored, no buf_we.
- XFER, write: on istb, sd_din <= buf_din[i] (the data for current buf_addr), then buf_addr += 1 and count += 1. The first istb occurs at the command byte and must load byte 0.
- XFER: sd_rd/sd_wr deassert on ack_r (IO controller has latched the request). On ack_f: count == 512 (read) or count >= 512 (write) -> pulse req_done[i], otherwise pulse req_err[i]. Then go DONE.
- DONE: one cycle. gnt = 0; pointer = i+1 mod NREQ. Go IDLE. A requester whose req line is still high on the DONE cycle is treated as a new request.
- A requester dropping req mid-transfer does not abort; the transfer completes and done/err is still pulsed.
- Simultaneous dstb and ack_f in one cycle: the byte is written and counted before the completion check.
- Reset mid-XFER: sd_rd/sd_wr low at once. The user I/O side recovers on its next CONF_DATA0.

Test Plan:
- Single read, req_rd[0]=1, lba 0x00001234 -> sd_rd=1 with sd_lba 0x1234; after ack rise sd_rd=0. 512 dout strobes with data = addr[7:0] -> buf_we x512, buf_addr 0..511, req_done[0] one pulse after ack fall.
- Single write, req_wr[1]=1, RAM1[n] = n^0xA5 -> sd_wr=1; 513 din strobes -> sd_din sequence 0xA5,0xA4,... matches RAM1[0..511]; req_done[1] pulse.
- Contention: req_rd = 2'b11 held continuously -> grants alternate 01,10,01; no back-to-back grant to the same requester.
- Timeout with TIMEOUT=100, no ack -> sd_rd drops and req_err pulses exactly 100 cycles after sd_rd rises; next grant goes to the other requester.
- Short read, ack falls after 300 strobes -> req_err pulse, no req_done, return to IDLE.
- reset_n low mid-XFER (byte 200) -> sd_rd, sd_wr, gnt, buf_we = 0 without waiting for a clock edge; after release a fresh request restarts at buf_addr 0.
